// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the hazard sequencer state encoding.
//   Opcode constants : the major opcodes (inst[6:0]) the sequencer needs to classify
//   NOP              : canonical ADDI x0,x0,0 that FD loads on a flush
//   hz_state_t       : hazard_ctrl FSM state encoding (also exported on ctrlState)
package riscv_pkg;

  localparam logic [6:0] R_TYPE             = 7'b0110011;
  localparam logic [6:0] I_TYPE_CALCUTATION = 7'b0010011;
  localparam logic [6:0] I_TYPE_JALR        = 7'b1100111;
  localparam logic [6:0] LOAD               = 7'b0000011;
  localparam logic [6:0] STORE              = 7'b0100011;
  localparam logic [6:0] B_TYPE             = 7'b1100011;
  localparam logic [6:0] J_TYPE             = 7'b1101111;
  localparam logic [6:0] LUI                = 7'b0110111;
  localparam logic [6:0] AUIPC              = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2,
    HZ_WAIT  = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_rs_use_decode.sv
// rs_use_decode: classifies the decode-stage opcode by which source registers
// it actually reads, so a load-use match on an unused field never stalls.
//   idOpcode : in  7  FD inst[6:0]
//   use1     : out 1  instruction reads rs1
//   use2     : out 1  instruction reads rs2
// Purely combinational.
module rs_use_decode
  import riscv_pkg::*;
(
  input  logic [6:0] idOpcode,
  output logic       use1,
  output logic       use2
);

  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (idOpcode)
      R_TYPE, STORE, B_TYPE: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      I_TYPE_CALCUTATION, I_TYPE_JALR, LOAD: begin
        use1 = 1'b1;
      end
      // JAL, LUI, AUIPC and anything unrecognised read no registers.
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the PC and the fetch/decode register.
// Inserts load-use stalls, taken-branch flushes and I-fetch wait states.
//
// Parameters
//   LOAD_LAT       (1..7) stall cycles on a load-use hazard
//   BRANCH_PENALTY (1..3) total flush cycles on a taken branch/jump
// Ports
//   CLK, RSTn      clock (rising edge), async active-low reset
//   idOpcode/idRs1/idRs2       decode-stage instruction fields
//   exRd/exMemRead/exBranchTaken  EX-stage status
//   imemReady      I-memory data valid this cycle
//   pcWrite/instWrite          PC and FD register enables
//   fdFlush/deBubble           FD loads NOP / DE loads a bubble
//   ctrlState      current FSM state (debug)
//   stallCnt/flushCnt          performance counters, only with HAZARD_PERF_EN
//
// Optional feature: define HAZARD_PERF_EN to add the saturating stall/flush
// counters and their ports.
//
// state | meaning
// RUN   | normal issue; also evaluates branch / fetch-wait / load-use events
// STALL | holding PC and FD for the remaining load-use cycles
// FLUSH | discarding wrong-path fetches after a taken branch
// WAIT  | holding until I-memory returns data
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int LOAD_LAT       = 1,
  parameter int BRANCH_PENALTY = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [6:0] idOpcode,
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic [4:0] exRd,
  input  logic       exMemRead,
  input  logic       exBranchTaken,
  input  logic       imemReady,
  output logic       pcWrite,
  output logic       instWrite,
  output logic       fdFlush,
  output logic       deBubble,
  output logic [1:0] ctrlState
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stallCnt,
  output logic [31:0] flushCnt
`endif
);

  if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
    $error("hazard_ctrl: LOAD_LAT must be in 1..7");
  end
  if (BRANCH_PENALTY < 1 || BRANCH_PENALTY > 3) begin : g_bad_branch_penalty
    $error("hazard_ctrl: BRANCH_PENALTY must be in 1..3");
  end

  // The entry cycle itself is the first stall/flush cycle, so the counter
  // reloads with (cycles - 2) and the state exits on cnt==0.
  localparam logic [2:0] LL_RELOAD = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;
  localparam logic [2:0] BP_RELOAD = (BRANCH_PENALTY > 1) ? 3'(BRANCH_PENALTY - 2) : 3'd0;

  hz_state_t  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic use1, use2;
  logic lu_haz;
  logic pc_write, inst_write, fd_flush, de_bubble;

  rs_use_decode u_rs_use_decode (
    .idOpcode (idOpcode),
    .use1     (use1),
    .use2     (use2)
  );

  assign lu_haz = exMemRead && (exRd != 5'd0) &&
                  ((use1 && (exRd == idRs1)) || (use2 && (exRd == idRs2)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    inst_write = 1'b1;
    fd_flush   = 1'b0;
    de_bubble  = 1'b0;

    // A taken branch wins in every state, abandoning any stall or wait.
    if (exBranchTaken) begin
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        state_d = HZ_FLUSH;
        cnt_d   = BP_RELOAD;
      end else begin
        state_d = HZ_RUN;
      end
    end else begin
      case (state_q)
        HZ_STALL: begin
          pc_write   = 1'b0;
          inst_write = 1'b0;
          de_bubble  = 1'b1;
          if (cnt_q == 3'd0) state_d = HZ_RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
        HZ_FLUSH: begin
          // FD holds wrong-path content, so load-use matches are meaningless here.
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
          if (cnt_q == 3'd0) state_d = HZ_RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
        default: begin
          // RUN, and WAIT on the cycle imemReady returns, share the RUN rules.
          if (!imemReady) begin
            pc_write   = 1'b0;
            inst_write = 1'b0;
            de_bubble  = 1'b1;
            state_d    = HZ_WAIT;
          end else if (lu_haz) begin
            pc_write   = 1'b0;
            inst_write = 1'b0;
            de_bubble  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = HZ_STALL;
              cnt_d   = LL_RELOAD;
            end else begin
              state_d = HZ_RUN;
            end
          end else begin
            state_d = HZ_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= HZ_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are combinational, so reset values are forced directly by RSTn.
  assign pcWrite   = RSTn & pc_write;
  assign instWrite = RSTn & inst_write;
  assign fdFlush   = ~RSTn | fd_flush;
  assign deBubble  = ~RSTn | de_bubble;
  assign ctrlState = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!pcWrite && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (fdFlush && (flush_cnt_q != 32'hFFFF_FFFF))  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import riscv_pkg::*;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [6:0] idOpcode = 7'd0;
  logic [4:0] idRs1 = 5'd0, idRs2 = 5'd0, exRd = 5'd0;
  logic       exMemRead = 1'b0, exBranchTaken = 1'b0, imemReady = 1'b1;

  logic       pc_a, iw_a, ff_a, db_a;
  logic [1:0] st_a;
  logic       pc_b, iw_b, ff_b, db_b;
  logic [1:0] st_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif

  always #5 CLK = ~CLK;

  hazard_ctrl #(.LOAD_LAT(1), .BRANCH_PENALTY(2)) dut (
    .CLK(CLK), .RSTn(RSTn), .idOpcode(idOpcode), .idRs1(idRs1), .idRs2(idRs2),
    .exRd(exRd), .exMemRead(exMemRead), .exBranchTaken(exBranchTaken), .imemReady(imemReady),
    .pcWrite(pc_a), .instWrite(iw_a), .fdFlush(ff_a), .deBubble(db_a), .ctrlState(st_a)
`ifdef HAZARD_PERF_EN
    , .stallCnt(sc_a), .flushCnt(fc_a)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(4), .BRANCH_PENALTY(2)) dut4 (
    .CLK(CLK), .RSTn(RSTn), .idOpcode(idOpcode), .idRs1(idRs1), .idRs2(idRs2),
    .exRd(exRd), .exMemRead(exMemRead), .exBranchTaken(exBranchTaken), .imemReady(imemReady),
    .pcWrite(pc_b), .instWrite(iw_b), .fdFlush(ff_b), .deBubble(db_b), .ctrlState(st_b)
`ifdef HAZARD_PERF_EN
    , .stallCnt(sc_b), .flushCnt(fc_b)
`endif
  );

  typedef struct {
    string      name;
    bit         sel;       // 0: LOAD_LAT=1 instance, 1: LOAD_LAT=4 instance
    logic       pc, iw, ff, db;
    logic [1:0] st;
    bit         zero_perf; // perf counters expected to read zero
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.sel) begin
        chk(e.name, "pcWrite",   32'(pc_a), 32'(e.pc));
        chk(e.name, "instWrite", 32'(iw_a), 32'(e.iw));
        chk(e.name, "fdFlush",   32'(ff_a), 32'(e.ff));
        chk(e.name, "deBubble",  32'(db_a), 32'(e.db));
        chk(e.name, "ctrlState", 32'(st_a), 32'(e.st));
      end else begin
        chk(e.name, "pcWrite",   32'(pc_b), 32'(e.pc));
        chk(e.name, "instWrite", 32'(iw_b), 32'(e.iw));
        chk(e.name, "fdFlush",   32'(ff_b), 32'(e.ff));
        chk(e.name, "deBubble",  32'(db_b), 32'(e.db));
        chk(e.name, "ctrlState", 32'(st_b), 32'(e.st));
      end
`ifdef HAZARD_PERF_EN
      if (e.zero_perf) begin
        chk(e.name, "stallCnt", e.sel ? sc_b : sc_a, 32'd0);
        chk(e.name, "flushCnt", e.sel ? fc_b : fc_a, 32'd0);
      end
`endif
    end
  end

  // One cycle: drive inputs just after the rising edge and queue the
  // hand-computed response for the selected instance.
  task automatic step(input string name, input bit sel, input logic rst_n,
                      input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mr, input logic br, input logic rdy,
                      input logic e_pc, input logic e_iw, input logic e_ff, input logic e_db,
                      input logic [1:0] e_st, input bit zp = 1'b0);
    exp_t e;
    @(posedge CLK);
    #1;
    RSTn = rst_n; idOpcode = opc; idRs1 = rs1; idRs2 = rs2; exRd = rd;
    exMemRead = mr; exBranchTaken = br; imemReady = rdy;
    e.name = name; e.sel = sel; e.pc = e_pc; e.iw = e_iw; e.ff = e_ff; e.db = e_db;
    e.st = e_st; e.zero_perf = zp;
    sb.push_back(e);
  endtask

  initial begin
    //   name        sel rst opc                 rs1 rs2 rd mr br rdy  pc iw ff db st
    step("reset",     0, 0, R_TYPE,              0,  0,  0, 0, 0, 1,   0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      step("run",     0, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 0, 0, 0);
    // Load-use, LOAD_LAT=1: one bubble, stays in RUN.
    step("lu_rs2",    0, 1, R_TYPE,              1,  5,  5, 1, 0, 1,   0, 0, 0, 1, 0);
    step("lu_after",  0, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 0, 0, 0);
    step("lu_load",   0, 1, LOAD,                7,  0,  7, 1, 0, 1,   0, 0, 0, 1, 0);
    step("lu_store",  0, 1, STORE,               1,  9,  9, 1, 0, 1,   0, 0, 0, 1, 0);
    // Suppressed hazards.
    step("nolu_x0",   0, 1, R_TYPE,              0,  0,  0, 1, 0, 1,   1, 1, 0, 0, 0);
    step("nolu_jal",  0, 1, J_TYPE,              5,  5,  5, 1, 0, 1,   1, 1, 0, 0, 0);
    step("nolu_lui",  0, 1, LUI,                 5,  5,  5, 1, 0, 1,   1, 1, 0, 0, 0);
    step("nolu_irs2", 0, 1, I_TYPE_CALCUTATION,  4,  5,  5, 1, 0, 1,   1, 1, 0, 0, 0);
    step("nolu_nomr", 0, 1, R_TYPE,              5,  5,  5, 0, 0, 1,   1, 1, 0, 0, 0);
    // Branch, BRANCH_PENALTY=2: RUN -> FLUSH -> RUN.
    step("br_take",   0, 1, R_TYPE,              1,  2,  3, 0, 1, 1,   1, 1, 1, 1, 0);
    step("br_flush",  0, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 1, 1, 2);
    step("br_done",   0, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 0, 0, 0);
    // Priority: branch beats not-ready and load-use; load-use ignored in FLUSH.
    step("pri_all",   0, 1, R_TYPE,              5,  2,  5, 1, 1, 0,   1, 1, 1, 1, 0);
    step("pri_flush", 0, 1, R_TYPE,              5,  2,  5, 1, 0, 1,   1, 1, 1, 1, 2);
    step("wait0",     0, 1, R_TYPE,              1,  2,  3, 0, 0, 0,   0, 0, 0, 1, 0);
    step("wait1",     0, 1, R_TYPE,              1,  2,  3, 0, 0, 0,   0, 0, 0, 1, 3);
    step("wait2",     0, 1, R_TYPE,              1,  2,  3, 0, 0, 0,   0, 0, 0, 1, 3);
    step("wait_exit", 0, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 0, 0, 3);
    step("post_wait", 0, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 0, 0, 0);
    // WAIT exit into a load-use, then a branch abandoning a wait.
    step("w_enter",   0, 1, R_TYPE,              1,  2,  3, 0, 0, 0,   0, 0, 0, 1, 0);
    step("w_lu",      0, 1, R_TYPE,              6,  2,  6, 1, 0, 1,   0, 0, 0, 1, 3);
    step("w_enter2",  0, 1, R_TYPE,              1,  2,  3, 0, 0, 0,   0, 0, 0, 1, 0);
    step("w_branch",  0, 1, R_TYPE,              1,  2,  3, 0, 1, 0,   1, 1, 1, 1, 3);
    step("w_flush",   0, 1, R_TYPE,              1,  2,  3, 0, 0, 0,   1, 1, 1, 1, 2);
    step("w_run",     0, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 0, 0, 0);

    // LOAD_LAT=4 instance.
    step("l4_reset",  1, 0, R_TYPE,              1,  2,  3, 0, 0, 1,   0, 0, 1, 1, 0, 1);
    step("l4_lu",     1, 1, R_TYPE,              5,  2,  5, 1, 0, 1,   0, 0, 0, 1, 0);
    step("l4_st2",    1, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   0, 0, 0, 1, 1);
    step("l4_st3",    1, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   0, 0, 0, 1, 1);
    step("l4_st4",    1, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   0, 0, 0, 1, 1);
    step("l4_run",    1, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 0, 0, 0);
    // Branch abandons a stall.
    step("l4_lu2",    1, 1, LOAD,                5,  0,  5, 1, 0, 1,   0, 0, 0, 1, 0);
    step("l4_br",     1, 1, R_TYPE,              1,  2,  3, 0, 1, 1,   1, 1, 1, 1, 1);
    step("l4_flush",  1, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 1, 1, 2);
    step("l4_run2",   1, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 0, 0, 0);
    // Reset in the second cycle of a stall.
    step("l4_lu3",    1, 1, R_TYPE,              5,  2,  5, 1, 0, 1,   0, 0, 0, 1, 0);
    step("l4_mid",    1, 0, R_TYPE,              1,  2,  3, 0, 0, 1,   0, 0, 1, 1, 0, 1);
    step("l4_rel",    1, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 0, 0, 0, 1);
    step("l4_rel2",   1, 1, R_TYPE,              1,  2,  3, 0, 0, 1,   1, 1, 0, 0, 0);

    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
